lfcc_sequencer: RTL and testbench



---
 rtl/lfcc_pkg.sv | 22 ++
 rtl/lfcc_tick_counter.sv | 36 +++
 rtl/lfcc_sequencer.sv | 136 +++++++++++++
 tb/tb_lfcc_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lfcc_pkg.sv
// Shared types and default constants for the LFCC soft-start sequencer.
package lfcc_pkg;

    localparam int LFCC_N_PERIOD          = 78;
    localparam int LFCC_PRECHARGE_PERIODS = 16;
    localparam int LFCC_RAMP_STEP_PERIODS = 8;
    localparam int LFCC_DUTY_MIN          = 1;
    localparam int DUTY_W                 = 7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_RAMP      = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lfcc_tick_counter.sv
// Saturating period_tick counter; done flags the tick that reaches terminal.
module lfcc_tick_counter #(
    parameter int CW = 5
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clear_i,
    input  logic          tick_i,
    input  logic [CW-1:0] terminal_i,
    output logic          done_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    assign done_o  = tick_i && (cnt_inc >= {1'b0, terminal_i});

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q != '1)) begin
            cnt_d = cnt_inc[CW-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lfcc_sequencer.sv
// Flying-cap precharge / duty soft-start sequencer for the two-phase LFCC stage.
module lfcc_sequencer
    import lfcc_pkg::*;
#(
    parameter int N_PERIOD          = LFCC_N_PERIOD,
    parameter int PRECHARGE_PERIODS = LFCC_PRECHARGE_PERIODS,
    parameter int RAMP_STEP_PERIODS = LFCC_RAMP_STEP_PERIODS,
    parameter int DUTY_MIN          = LFCC_DUTY_MIN
) (
    input  logic              clk_pwm,
    input  logic              reset,
    input  logic              start,
    input  logic              fault,
    input  logic              fault_clr,
    input  logic              period_tick,
    input  logic [DUTY_W-1:0] duty_target,
    output logic [DUTY_W-1:0] duty,
    output logic              pwm_en,
    output logic              precharge_en,
    output logic [2:0]        state
);

    localparam int CW = $clog2(imax(PRECHARGE_PERIODS, RAMP_STEP_PERIODS)) + 1;

    state_e            state_q;
    logic [DUTY_W-1:0] duty_q;
    logic              pwm_en_q;
    logic              pre_en_q;
    logic [DUTY_W-1:0] tgt;
    logic              in_count;
    logic              cnt_clr;
    logic              cnt_done;
    logic [CW-1:0]     cnt_term;

    always_comb begin
        tgt = duty_target;
        if (duty_target == '0) begin
            tgt = DUTY_W'(DUTY_MIN);
        end else if (duty_target > DUTY_W'(N_PERIOD)) begin
            tgt = DUTY_W'(N_PERIOD);
        end
    end

    // Counter only runs while precharging or ramping; every exit or step restarts it.
    assign in_count = (state_q == ST_PRECHARGE) || (state_q == ST_RAMP);
    assign cnt_clr  = !in_count || fault || !start || cnt_done;
    assign cnt_term = (state_q == ST_PRECHARGE) ? CW'(PRECHARGE_PERIODS)
                                                : CW'(RAMP_STEP_PERIODS);

    lfcc_tick_counter #(
        .CW(CW)
    ) u_cnt (
        .clk_i     (clk_pwm),
        .reset_i   (reset),
        .clear_i   (cnt_clr),
        .tick_i    (period_tick),
        .terminal_i(cnt_term),
        .done_o    (cnt_done)
    );

    always_ff @(posedge clk_pwm) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            duty_q   <= '0;
            pwm_en_q <= 1'b0;
            pre_en_q <= 1'b0;
        end else if (fault) begin
            state_q  <= ST_FAULT;
            duty_q   <= '0;
            pwm_en_q <= 1'b0;
            pre_en_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_PRECHARGE;
                        pre_en_q <= 1'b1;
                    end
                end
                ST_PRECHARGE: begin
                    if (!start) begin
                        state_q  <= ST_IDLE;
                        duty_q   <= '0;
                        pwm_en_q <= 1'b0;
                        pre_en_q <= 1'b0;
                    end else if (cnt_done) begin
                        state_q  <= ST_RAMP;
                        duty_q   <= DUTY_W'(DUTY_MIN);
                        pwm_en_q <= 1'b1;
                        pre_en_q <= 1'b0;
                    end
                end
                ST_RAMP: begin
                    if (!start) begin
                        state_q  <= ST_IDLE;
                        duty_q   <= '0;
                        pwm_en_q <= 1'b0;
                        pre_en_q <= 1'b0;
                    end else if (duty_q == tgt) begin
                        state_q <= ST_RUN;
                    end else if (cnt_done) begin
                        duty_q <= (duty_q < tgt) ? duty_q + DUTY_W'(1)
                                                 : duty_q - DUTY_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!start) begin
                        state_q  <= ST_IDLE;
                        duty_q   <= '0;
                        pwm_en_q <= 1'b0;
                        pre_en_q <= 1'b0;
                    end else if (duty_q != tgt) begin
                        state_q <= ST_RAMP;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr && !start) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q  <= ST_FAULT;
                    duty_q   <= '0;
                    pwm_en_q <= 1'b0;
                    pre_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign duty         = duty_q;
    assign pwm_en       = pwm_en_q;
    assign precharge_en = pre_en_q;
    assign state        = state_q;

endmodule

// File: tb/tb_lfcc_sequencer.sv
// Directed self-checking bench for lfcc_sequencer.
module tb_lfcc_sequencer;
    import lfcc_pkg::*;

    logic       clk_pwm = 1'b0;
    logic       reset;
    logic       start;
    logic       fault;
    logic       fault_clr;
    logic       period_tick;
    logic [6:0] duty_target;
    logic [6:0] duty;
    logic       pwm_en;
    logic       precharge_en;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_pwm = ~clk_pwm;

    lfcc_sequencer dut (
        .clk_pwm     (clk_pwm),
        .reset       (reset),
        .start       (start),
        .fault       (fault),
        .fault_clr   (fault_clr),
        .period_tick (period_tick),
        .duty_target (duty_target),
        .duty        (duty),
        .pwm_en      (pwm_en),
        .precharge_en(precharge_en),
        .state       (state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int d,
                           input int pe, input int pc);
        chk({tag, ".state"}, 32'(state), st);
        chk({tag, ".duty"}, 32'(duty), d);
        chk({tag, ".pwm_en"}, 32'(pwm_en), pe);
        chk({tag, ".precharge_en"}, 32'(precharge_en), pc);
    endtask

    task automatic cyc();
        @(posedge clk_pwm);
        #1;
    endtask

    task automatic period(input int gap);
        period_tick = 1'b1;
        cyc();
        period_tick = 1'b0;
        repeat (gap - 1) cyc();
    endtask

    task automatic periods(input int n, input int gap);
        for (int i = 0; i < n; i++) period(gap);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        fault       = 1'b0;
        fault_clr   = 1'b0;
        period_tick = 1'b0;
        duty_target = 7'd40;
        cyc();
        cyc();
        reset = 1'b0;
        chk_all("reset", 0, 0, 0, 0);

        // normal start, 80-cycle carrier
        start = 1'b1;
        cyc();
        chk_all("pre_entry", 1, 0, 0, 1);
        periods(15, 80);
        chk_all("pre_15", 1, 0, 0, 1);
        period(80);
        chk_all("ramp_entry", 2, 1, 1, 0);
        for (int i = 1; i <= 312; i++) begin
            period(80);
            if (i == 7) chk("ramp_t7.duty", 32'(duty), 1);
            if (i == 8) chk("ramp_t8.duty", 32'(duty), 2);
        end
        chk_all("run_40", 3, 40, 1, 0);

        // retarget downward
        duty_target = 7'd35;
        cyc();
        chk_all("retgt_ramp", 2, 40, 1, 0);
        periods(8, 4);
        chk("retgt_t8.duty", 32'(duty), 39);
        periods(32, 4);
        chk_all("retgt_run", 3, 35, 1, 0);

        // abort from run, then during precharge
        start = 1'b0;
        cyc();
        chk_all("abort_run", 0, 0, 0, 0);
        start       = 1'b1;
        duty_target = 7'd40;
        cyc();
        periods(3, 4);
        chk("abort_pre.before", 32'(state), 1);
        start = 1'b0;
        cyc();
        chk_all("abort_pre", 0, 0, 0, 0);

        // clamp low, then reset while running
        start       = 1'b1;
        duty_target = 7'd0;
        cyc();
        periods(16, 4);
        chk_all("clamp0_run", 3, 1, 1, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_all("reset_run", 0, 0, 0, 0);

        // clamp high
        duty_target = 7'd120;
        cyc();
        periods(16 + 616, 2);
        chk_all("clamp120_run", 3, 78, 1, 0);

        // fault coincident with a tick mid-ramp
        duty_target = 7'd70;
        cyc();
        chk("fault_pre.state", 32'(state), 2);
        periods(3, 2);
        fault       = 1'b1;
        period_tick = 1'b1;
        cyc();
        fault       = 1'b0;
        period_tick = 1'b0;
        chk_all("fault_entry", 4, 0, 0, 0);
        cyc();
        chk("fault_latched.state", 32'(state), 4);
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
        chk("fault_clr_start.state", 32'(state), 4);
        start = 1'b0;
        cyc();
        chk("fault_noclr.state", 32'(state), 4);
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
        chk_all("fault_exit", 0, 0, 0, 0);

        // illegal state code from precharge
        start       = 1'b1;
        duty_target = 7'd40;
        cyc();
        chk("illegal_pre.pc", 32'(precharge_en), 1);
        force dut.state_q = state_e'(3'd6);
        #1;
        release dut.state_q;
        cyc();
        chk_all("illegal", 4, 0, 0, 0);
        start     = 1'b0;
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
        chk("illegal_exit.state", 32'(state), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
